// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - state encoding and width helper shared by the stopwatch files
package stopwatch_pkg;

    // Encoding is visible on the status output, so the values are fixed.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        DONE    = 2'b11
    } sw_state_t;

    // Occupancy counter must be able to hold the value DEPTH itself.
    function automatic int lap_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stopwatch_lap_ctrl_lap_fifo.sv
// rtl/stopwatch_lap_ctrl_lap_fifo.sv - show-ahead lap FIFO, any depth >= 1
// Ports: clk, rst_n (async active-low), flush (sync clear), push/push_data,
//        pop, pop_data (head, 0 when empty), full, empty, count.
module lap_fifo
    import stopwatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        push,
    input  logic [W-1:0]                push_data,
    input  logic                        pop,
    output logic [W-1:0]                pop_data,
    output logic                        full,
    output logic                        empty,
    output logic [lap_cnt_w(DEPTH)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = lap_cnt_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];
    assign count    = cnt_q;

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// rtl/stopwatch_lap_ctrl.sv - stopwatch FSM with prescaler, saturating counter and lap FIFO
// Optional countdown mode: define STOPWATCH_COUNTDOWN_EN (adds down, load_val).
// Ports: clk, rst_n (async active-low), clr (sync clear), start/stop/lap buttons
//        (rising-edge acting), lap_rd (FIFO pop); enable, status, tick, elapsed,
//        overflow, lap_valid, lap_data, lap_count, lap_ovf.
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV   = 100000,
    parameter int CNT_W     = 32,
    parameter int LAP_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr,
    input  logic                            start,
    input  logic                            stop,
    input  logic                            lap,
    input  logic                            lap_rd,
`ifdef STOPWATCH_COUNTDOWN_EN
    input  logic                            down,
    input  logic [CNT_W-1:0]                load_val,
`endif
    output logic                            enable,
    output logic [1:0]                      status,
    output logic                            tick,
    output logic [CNT_W-1:0]                elapsed,
    output logic                            overflow,
    output logic                            lap_valid,
    output logic [CNT_W-1:0]                lap_data,
    output logic [lap_cnt_w(LAP_DEPTH)-1:0] lap_count,
    output logic                            lap_ovf
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    sw_state_t      state_q, state_d;
    logic           start_q, stop_q, lap_q, armed_q;
    logic           start_rise, stop_rise, lap_rise;
    logic [PW-1:0]  presc_q;
    logic [CNT_W-1:0] elapsed_q;
    logic           overflow_q, lap_ovf_q;
    logic           tick_due, at_term, count_down, load_zero, go_run;
    logic           lap_push, fifo_pop, fifo_full, fifo_empty;

    // armed_q masks the first cycle after reset so a button already held
    // at release is seen as "previously high" rather than as a new press.
    assign start_rise = armed_q & start & ~start_q;
    assign stop_rise  = armed_q & stop  & ~stop_q;
    assign lap_rise   = armed_q & lap   & ~lap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            lap_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            start_q <= start;
            stop_q  <= stop;
            lap_q   <= lap;
            armed_q <= 1'b1;
        end
    end

`ifdef STOPWATCH_COUNTDOWN_EN
    logic down_q;
    assign count_down = down_q;
    assign load_zero  = down & (load_val == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      down_q <= 1'b0;
        else if (clr)    down_q <= 1'b0;
        else if (go_run) down_q <= down;
    end
`else
    assign count_down = 1'b0;
    assign load_zero  = 1'b0;
`endif

    // stop outranks start, so a simultaneous press never leaves IDLE.
    assign go_run   = (state_q == IDLE) & start_rise & ~stop_rise & ~clr;
    assign tick_due = (state_q == RUNNING) & (presc_q == PW'(CLK_DIV - 1)) & ~clr;
    assign at_term  = count_down ? (elapsed_q == CNT_W'(1)) : (elapsed_q == '1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_rise && !stop_rise) state_d = load_zero ? DONE : RUNNING;
            RUNNING: begin
                if (tick_due && at_term) state_d = DONE;
                else if (stop_rise)      state_d = PAUSED;
            end
            PAUSED:  if (start_rise && !stop_rise) state_d = RUNNING;
            default: state_d = state_q;
        endcase
        if (clr) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            elapsed_q  <= '0;
            overflow_q <= 1'b0;
        end else if (clr) begin
            presc_q    <= '0;
            elapsed_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
`ifdef STOPWATCH_COUNTDOWN_EN
            if (go_run && down) elapsed_q <= load_val;
            if (go_run && load_zero) overflow_q <= 1'b1;
`endif
            // Only RUNNING advances the prescaler; PAUSED keeps the partial period.
            if (state_q == RUNNING) begin
                presc_q <= tick_due ? '0 : presc_q + 1'b1;
                if (tick_due) begin
                    if (at_term) overflow_q <= 1'b1;
                    if (count_down)    elapsed_q <= elapsed_q - 1'b1;
                    else if (!at_term) elapsed_q <= elapsed_q + 1'b1;
                end
            end
        end
    end

    // The pushed value is elapsed before this cycle's increment.
    assign lap_push = lap_rise & ((state_q == RUNNING) | (state_q == PAUSED)) & ~clr;
    assign fifo_pop = lap_rd & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 lap_ovf_q <= 1'b0;
        else if (clr)                               lap_ovf_q <= 1'b0;
        else if (lap_push && fifo_full && !lap_rd)  lap_ovf_q <= 1'b1;
    end

    lap_fifo #(
        .DEPTH (LAP_DEPTH),
        .W     (CNT_W)
    ) u_lap_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (clr),
        .push      (lap_push),
        .push_data (elapsed_q),
        .pop       (fifo_pop),
        .pop_data  (lap_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (lap_count)
    );

    assign enable    = (state_q == RUNNING);
    assign status    = state_q;
    assign tick      = tick_due;
    assign elapsed   = elapsed_q;
    assign overflow  = overflow_q;
    assign lap_valid = ~fifo_empty;
    assign lap_ovf   = lap_ovf_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// tb/tb_stopwatch_lap_ctrl.sv - directed and random checks of stopwatch_lap_ctrl against a reference model
module tb_stopwatch_lap_ctrl;

    localparam int CLK_DIV   = 4;
    localparam int CNT_W     = 4;
    localparam int LAP_DEPTH = 2;
    localparam int MAXV      = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0, start = 1'b0, stop = 1'b0, lap = 1'b0, lap_rd = 1'b0;
`ifdef STOPWATCH_COUNTDOWN_EN
    logic             down = 1'b0;
    logic [CNT_W-1:0] load_val = '0;
`endif
    logic             enable, tick, overflow, lap_valid, lap_ovf;
    logic [1:0]       status;
    logic [CNT_W-1:0] elapsed, lap_data;
    logic [1:0]       lap_count;

    stopwatch_lap_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .CNT_W     (CNT_W),
        .LAP_DEPTH (LAP_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .start     (start),
        .stop      (stop),
        .lap       (lap),
        .lap_rd    (lap_rd),
`ifdef STOPWATCH_COUNTDOWN_EN
        .down      (down),
        .load_val  (load_val),
`endif
        .enable    (enable),
        .status    (status),
        .tick      (tick),
        .elapsed   (elapsed),
        .overflow  (overflow),
        .lap_valid (lap_valid),
        .lap_data  (lap_data),
        .lap_count (lap_count),
        .lap_ovf   (lap_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: state 0 idle, 1 running, 2 paused, 3 done.
    int m_st, m_el, m_ph;
    bit m_ovf, m_lovf, m_down, m_armed;
    bit p_start, p_stop, p_lap;
    int q[$];
    bit last_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_el = 0; m_ph = 0; m_ovf = 0; m_lovf = 0; m_down = 0; m_armed = 0;
        p_start = 0; p_stop = 0; p_lap = 0;
        q.delete();
    endtask

    task automatic model_update();
        bit sr, spr, lr, push, pop, expire;
        sr  = m_armed && start && !p_start;
        spr = m_armed && stop  && !p_stop;
        lr  = m_armed && lap   && !p_lap;
        m_armed = 1; p_start = start; p_stop = stop; p_lap = lap;
        if (clr) begin
            m_st = 0; m_el = 0; m_ph = 0; m_ovf = 0; m_lovf = 0; m_down = 0;
            q.delete();
            return;
        end
        push = lr && (m_st == 1 || m_st == 2);
        pop  = lap_rd && q.size() > 0;
        if (push && q.size() == LAP_DEPTH && !pop) m_lovf = 1;
        else begin
            if (pop)  q.delete(0);
            if (push) q.push_back(m_el);
        end
        expire = 0;
        case (m_st)
            0: if (sr && !spr) begin
`ifdef STOPWATCH_COUNTDOWN_EN
                m_down = down;
                if (down) begin
                    m_el = int'(load_val);
                    if (load_val == 0) begin m_st = 3; m_ovf = 1; end
                    else m_st = 1;
                end else m_st = 1;
`else
                m_st = 1;
`endif
            end
            1: begin
                if (m_ph == CLK_DIV - 1) begin
                    m_ph = 0;
                    if (m_down) begin m_el = m_el - 1; expire = (m_el == 0); end
                    else if (m_el == MAXV) expire = 1;
                    else m_el = m_el + 1;
                end else m_ph = m_ph + 1;
                if (expire) begin m_ovf = 1; m_st = 3; end
                else if (spr) m_st = 2;
            end
            2: if (sr && !spr) m_st = 1;
            default: ;
        endcase
    endtask

    task automatic check_regs();
        chk("status",    32'(status),    32'(m_st));
        chk("enable",    32'(enable),    32'(m_st == 1));
        chk("elapsed",   32'(elapsed),   32'(m_el));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("lap_valid", 32'(lap_valid), 32'(q.size() > 0));
        chk("lap_count", 32'(lap_count), 32'(q.size()));
        chk("lap_data",  32'(lap_data),  (q.size() > 0) ? 32'(q[0]) : 32'd0);
        chk("lap_ovf",   32'(lap_ovf),   32'(m_lovf));
    endtask

    // Called at posedge+1 with inputs already set for the coming cycle.
    task automatic cycle();
        #2;
        last_tick = tick;
        chk("tick", 32'(tick), 32'(m_st == 1 && m_ph == CLK_DIV - 1 && !clr));
        model_update();
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic run_until_el(input int k);
        for (int i = 0; i < 200 && m_el != k; i++) cycle();
        chk("reach_elapsed", 32'(elapsed), 32'(k));
    endtask

    task automatic press_lap();
        lap = 1; cycle(); lap = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        start = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_status",    32'(status),    0);
        chk("rst_enable",    32'(enable),    0);
        chk("rst_tick",      32'(tick),      0);
        chk("rst_elapsed",   32'(elapsed),   0);
        chk("rst_overflow",  32'(overflow),  0);
        chk("rst_lap_valid", 32'(lap_valid), 0);
        chk("rst_lap_data",  32'(lap_data),  0);
        chk("rst_lap_count", 32'(lap_count), 0);
        chk("rst_lap_ovf",   32'(lap_ovf),   0);
        model_reset();
        rst_n = 1;

        // start held high across reset release must not start the watch
        repeat (4) cycle();
        chk("held_start_idle", 32'(status), 0);

        // run 12 cycles: three ticks
        start = 0; cycle();
        start = 1; cycle(); start = 0;
        n = 0;
        repeat (12) begin cycle(); n += int'(last_tick); end
        chk("t1_ticks",   32'(n),       3);
        chk("t1_elapsed", 32'(elapsed), 3);
        chk("t1_enable",  32'(enable),  1);
        chk("t1_status",  32'(status),  1);

        // pause preserves the partial prescaler period
        clr = 1; cycle(); clr = 0;
        chk("t2_clr_status", 32'(status), 0);
        start = 1; cycle(); start = 0;
        repeat (8) cycle();
        chk("t2_el2", 32'(elapsed), 2);
        cycle();
        stop = 1; cycle(); stop = 0;
        chk("t2_paused", 32'(status), 2);
        repeat (20) cycle();
        chk("t2_hold_el", 32'(elapsed), 2);
        start = 1; cycle(); start = 0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(); n++;
            if (last_tick) break;
        end
        chk("t2_resume_latency", 32'(n), 2);
        chk("t2_el3", 32'(elapsed), 3);

        // laps: two fit, third dropped, pop, then push+pop while full
        clr = 1; cycle(); clr = 0;
        start = 1; cycle(); start = 0;
        run_until_el(1); press_lap();
        run_until_el(2); press_lap();
        run_until_el(3); press_lap();
        chk("t3_count", 32'(lap_count), 2);
        chk("t3_data",  32'(lap_data),  1);
        chk("t3_ovf",   32'(lap_ovf),   1);
        lap_rd = 1; cycle(); lap_rd = 0;
        chk("t3_pop_data", 32'(lap_data), 2);
        run_until_el(4); press_lap();
        chk("t3_full", 32'(lap_count), 2);
        cycle();
        lap = 1; lap_rd = 1; cycle(); lap = 0; lap_rd = 0;
        chk("t3_pushpop_count", 32'(lap_count), 2);
        chk("t3_pushpop_data",  32'(lap_data),  4);

        // saturation into DONE
        for (int i = 0; i < 300 && m_st != 3; i++) cycle();
        chk("t4_elapsed",  32'(elapsed),  MAXV);
        chk("t4_overflow", 32'(overflow), 1);
        chk("t4_status",   32'(status),   3);
        start = 1; cycle(); start = 0; cycle();
        chk("t4_start_ignored", 32'(status), 3);
        clr = 1; cycle(); clr = 0;
        chk("t4_clr_status",  32'(status),    0);
        chk("t4_clr_elapsed", 32'(elapsed),   0);
        chk("t4_clr_fifo",    32'(lap_valid), 0);

        // clr beats start in PAUSED
        start = 1; cycle(); start = 0;
        repeat (3) cycle();
        stop = 1; cycle(); stop = 0;
        chk("t5_paused", 32'(status), 2);
        start = 1; clr = 1; cycle(); clr = 0; start = 0;
        chk("t5_clr_start", 32'(status), 0);
        cycle();
        chk("t5_stay_idle", 32'(status), 0);

`ifdef STOPWATCH_COUNTDOWN_EN
        down = 1; load_val = 4'd3;
        start = 1; cycle(); start = 0;
        chk("t6_loaded", 32'(elapsed), 3);
        run_until_el(2);
        run_until_el(1);
        run_until_el(0);
        chk("t6_done",     32'(status),   3);
        chk("t6_overflow", 32'(overflow), 1);
        clr = 1; cycle(); clr = 0;
        load_val = 4'd0;
        start = 1; cycle(); start = 0;
        chk("t6_zero_done", 32'(status), 3);
        clr = 1; cycle(); clr = 0;
        down = 0;
`endif

        // random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            start  = ($urandom_range(0, 9) == 0);
            stop   = ($urandom_range(0, 29) == 0);
            lap    = ($urandom_range(0, 5) == 0);
            lap_rd = ($urandom_range(0, 3) == 0);
            clr    = ($urandom_range(0, 299) == 0);
`ifdef STOPWATCH_COUNTDOWN_EN
            down     = ($urandom_range(0, 1) == 0);
            load_val = CNT_W'($urandom_range(0, 5));
`endif
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
